seg7_scan: RTL

Parametrised multi-digit, time-multiplexed 7-segment display driver. It is the successor to the single-digit 4-bit hex-to-segment decoder. It holds a DIGITS-nibble display word and scans one digit at a time at a prescaled refresh rate, driving shared segment lines plus a one-hot digit enable. New values are loaded through a tear-free handshake and applied only at frame boundaries. Per-digit blanking and decimal points are supported.

---
 rtl/seg7_scan.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan
//  Function : Time-multiplexed multi-digit 7-segment driver with frame-aligned,
//             tear-free loads. Optional macro: LEADING_ZERO_BLANK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan #(
    parameter int DIGITS = 4,
    parameter int DIV    = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    output logic                  done,
    output logic [6:0]            y,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);

    localparam int                 CNT_W    = $clog2(DIV);
    localparam int                 IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                pend_q, pend_d;
    logic [4*DIGITS-1:0] p_data_q, p_data_d;
    logic [DIGITS-1:0]   p_dp_q, p_dp_d;
    logic [DIGITS-1:0]   p_blank_q, p_blank_d;
    logic [4*DIGITS-1:0] d_data_q, d_data_d;
    logic [DIGITS-1:0]   d_dp_q, d_dp_d;
    logic [DIGITS-1:0]   d_blank_q, d_blank_d;
    logic                done_q, done_d;
    logic [6:0]          y_q, y_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic                tick;
    logic                boundary;
    logic [DIGITS-1:0]   lz_blank;
    logic                higher_zero;
    logic [3:0]          sel_nib;
    logic                sel_dp;
    logic                sel_blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0:    seg_decode = 7'b1111110;
            4'h1:    seg_decode = 7'b0110000;
            4'h2:    seg_decode = 7'b1101101;
            4'h3:    seg_decode = 7'b1111001;
            4'h4:    seg_decode = 7'b0110011;
            4'h5:    seg_decode = 7'b1011011;
            4'h6:    seg_decode = 7'b1011111;
            4'h7:    seg_decode = 7'b1110000;
            4'h8:    seg_decode = 7'b1111111;
            4'h9:    seg_decode = 7'b1111011;
            4'hA:    seg_decode = 7'b1110111;
            4'hB:    seg_decode = 7'b0011111;
            4'hC:    seg_decode = 7'b1001110;
            4'hD:    seg_decode = 7'b0111101;
            4'hE:    seg_decode = 7'b1001111;
            default: seg_decode = 7'b1000111;
        endcase
    endfunction

    assign tick     = (cnt_q == CNT_LAST);
    assign boundary = tick && (idx_q == IDX_LAST);

    // Prescaler, digit index and the pending/display word handoff
    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        pend_d    = pend_q;
        p_data_d  = p_data_q;
        p_dp_d    = p_dp_q;
        p_blank_d = p_blank_q;
        d_data_d  = d_data_q;
        d_dp_d    = d_dp_q;
        d_blank_d = d_blank_q;
        done_d    = 1'b0;

        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        if (boundary && load) begin
            // A load landing on the boundary bypasses (and discards) P
            d_data_d  = data_in;
            d_dp_d    = dp_in;
            d_blank_d = blank_in;
            pend_d    = 1'b0;
            done_d    = 1'b1;
        end else if (boundary && pend_q) begin
            d_data_d  = p_data_q;
            d_dp_d    = p_dp_q;
            d_blank_d = p_blank_q;
            pend_d    = 1'b0;
            done_d    = 1'b1;
        end else if (load) begin
            p_data_d  = data_in;
            p_dp_d    = dp_in;
            p_blank_d = blank_in;
            pend_d    = 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk from the top digit down; a digit is suppressed while everything
    // at and above it is zero. Digit 0 always stays lit.
    always_comb begin
        higher_zero = 1'b1;
        lz_blank    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            higher_zero = higher_zero & (d_data_q[4*i +: 4] == 4'h0);
            lz_blank[i] = higher_zero & (i != 0);
        end
    end
`else
    assign higher_zero = 1'b0;
    assign lz_blank    = '0;
`endif

    // Output stage: decode the digit currently selected by idx
    always_comb begin
        sel_nib   = 4'h0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        an_d      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_nib   = d_data_q[4*i +: 4];
                sel_dp    = d_dp_q[i];
                sel_blank = d_blank_q[i] | lz_blank[i];
                an_d[i]   = 1'b1;
            end
        end
        y_d  = sel_blank ? 7'b0 : seg_decode(sel_nib);
        dp_d = sel_dp & ~sel_blank;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            pend_q    <= 1'b0;
            p_data_q  <= '0;
            p_dp_q    <= '0;
            p_blank_q <= '0;
            d_data_q  <= '0;
            d_dp_q    <= '0;
            d_blank_q <= '0;
            done_q    <= 1'b0;
            y_q       <= '0;
            dp_q      <= 1'b0;
            an_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            p_data_q  <= p_data_d;
            p_dp_q    <= p_dp_d;
            p_blank_q <= p_blank_d;
            d_data_q  <= d_data_d;
            d_dp_q    <= d_dp_d;
            d_blank_q <= d_blank_d;
            done_q    <= done_d;
            y_q       <= y_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
        end
    end

    assign done = done_q;
    assign y    = y_q;
    assign dp   = dp_q;
    assign an   = an_q;

endmodule
`default_nettype wire
